spi_byte_master: RTL and testbench

- Byte-wide SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first.
- Sits between the CPU core's control logic and the uio pad mapping: the CPU issues byte transfers, and this block drives spi_cs_n/spi_sck/spi_mosi and samples spi_miso.
- Provides a start/busy/done handshake, a programmable SCK rate, and optional chip-select hold across consecutive bytes for multi-byte commands.

---
 rtl/spi_byte_master_pkg.sv | 21 ++
 rtl/spi_byte_master_phase_timer.sv | 31 +++
 rtl/spi_byte_master.sv | 148 ++++++++++++++
 tb/tb_spi_byte_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_master_pkg.sv
// Shared SPI definitions: FSM state encodings, mode constants and the default
// SCK divider. Also imported by the spi_cpu core.
package spi_byte_master_pkg;

    // Mode 0 only: SCK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    // Default SCK half-period in clk cycles.
    localparam int DEFAULT_CLK_DIV = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } spi_state_t;

endpackage

// File: rtl/spi_byte_master_phase_timer.sv
// Phase timer for the SPI master: a loadable down-counter that emits a
// one-cycle phase_end tick on the last cycle of every DIV-cycle phase.
module spi_phase_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic phase_end
);

    localparam int CW = $clog2(DIV + 1);

    logic [CW-1:0] cnt;

    // Last cycle of the phase: the counter has run down to one.
    assign phase_end = en && (cnt == CW'(1));

    // Reload while parked and at every phase boundary, otherwise count down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CW'(DIV);
        end else if (load || phase_end) begin
            cnt <= CW'(DIV);
        end else if (en) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-wide SPI mode-0 master, MSB first. Takes byte transfers from the CPU
// via start/busy/done and can keep CS asserted across bytes for multi-byte
// commands; cs_release drops a held CS.
module spi_byte_master
    import spi_byte_master_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       hold_cs,
    input  logic       cs_release,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       spi_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_byte_master: CLK_DIV must be in 1..255");
    end

    if (SPI_CPOL != 1'b0 || SPI_CPHA != 1'b0) begin : g_bad_mode
        $error("spi_byte_master: only SPI mode 0 is implemented");
    end

    spi_state_t state;
    logic [6:0] tx_sh;      // bits still to send after the one on spi_mosi
    logic [7:0] rx_sh;
    logic [2:0] bit_cnt;
    logic       hold_q;     // hold_cs latched at accept
    logic       cs_held;    // CS left asserted by a previous hold_cs byte
    logic       from_xfer;  // CS_HOLD entered at the end of a byte, not a release

    logic timer_en;
    logic phase_end;

    // IDLE and DONE are untimed; the counter stays loaded there so every
    // timed state starts with a full CLK_DIV phase.
    assign timer_en = (state != ST_IDLE) && (state != ST_DONE);

    spi_phase_timer #(
        .DIV(CLK_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (!timer_en),
        .en       (timer_en),
        .phase_end(phase_end)
    );

    // Transfer FSM with registered pad outputs and shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            spi_cs_n  <= 1'b1;
            spi_sck   <= SPI_CPOL;
            spi_mosi  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rx_data   <= 8'h00;
            tx_sh     <= 7'h00;
            rx_sh     <= 8'h00;
            bit_cnt   <= 3'd0;
            hold_q    <= 1'b0;
            cs_held   <= 1'b0;
            from_xfer <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start) begin
                        // Accept: a held CS skips the setup phase.
                        tx_sh    <= tx_data[6:0];
                        spi_mosi <= tx_data[7];
                        hold_q   <= hold_cs;
                        bit_cnt  <= 3'd7;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_sck  <= SPI_CPOL;
                        state    <= cs_held ? ST_SHIFT_LO : ST_CS_SETUP;
                    end else if (state == ST_IDLE && cs_release && cs_held) begin
                        busy      <= 1'b1;
                        from_xfer <= 1'b0;
                        state     <= ST_CS_HOLD;
                    end
                end
                ST_CS_SETUP: begin
                    if (phase_end) state <= ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    if (phase_end) begin
                        // Rising SCK edge: capture MISO.
                        spi_sck <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], spi_miso};
                        state   <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_end) begin
                        spi_sck <= 1'b0;
                        if (bit_cnt == 3'd0) begin
                            // Last bit: mosi stays on bit 0.
                            if (hold_q) begin
                                cs_held <= 1'b1;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                rx_data <= rx_sh;
                                state   <= ST_DONE;
                            end else begin
                                from_xfer <= 1'b1;
                                state     <= ST_CS_HOLD;
                            end
                        end else begin
                            // Falling SCK edge: present the next bit.
                            bit_cnt  <= bit_cnt - 3'd1;
                            spi_mosi <= tx_sh[6];
                            tx_sh    <= {tx_sh[5:0], 1'b0};
                            state    <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_CS_HOLD: begin
                    if (phase_end) begin
                        spi_cs_n <= 1'b1;
                        cs_held  <= 1'b0;
                        busy     <= 1'b0;
                        if (from_xfer) begin
                            done    <= 1'b1;
                            rx_data <= rx_sh;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: a CLK_DIV=2 instance with an SPI slave
// model and a CLK_DIV=1 instance with MISO tied low.
module tb_spi_byte_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // CLK_DIV=2 instance
    logic       start = 1'b0, hold = 1'b0, rel = 1'b0;
    logic [7:0] tx = 8'h00;
    logic       busy, done, cs_n, sck, mosi;
    logic [7:0] rx;

    // CLK_DIV=1 instance
    logic       start1 = 1'b0, hold1 = 1'b0, rel1 = 1'b0, miso1 = 1'b0;
    logic [7:0] tx1 = 8'h00;
    logic       busy1, done1, cs_n1, sck1, mosi1;
    logic [7:0] rx1;

    int total = 0;
    int bad   = 0;

    // Slave model: drives sbyte MSB first, advancing on each falling SCK.
    int         nfall = 0;
    int         sbase = 0;
    logic [7:0] sbyte = 8'h00;
    logic [2:0] sidx;
    logic       miso;
    assign sidx = 3'(nfall - sbase);
    assign miso = sbyte[~sidx];
    always @(negedge sck) nfall++;

    // MOSI as seen by the slave at each rising SCK.
    logic [7:0] mcap = 8'h00, mcap1 = 8'h00;
    int         nsck = 0, nsck1 = 0;
    always @(posedge sck)  begin mcap  = {mcap[6:0], mosi};   nsck++;  end
    always @(posedge sck1) begin mcap1 = {mcap1[6:0], mosi1}; nsck1++; end

    spi_byte_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx), .hold_cs(hold),
        .cs_release(rel), .busy(busy), .done(done), .rx_data(rx),
        .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
    );

    spi_byte_master #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .hold_cs(hold1),
        .cs_release(rel1), .busy(busy1), .done(done1), .rx_data(rx1),
        .spi_cs_n(cs_n1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 = start high; returns in cycle 1 with start/cs_release dropped.
    task automatic accept(input logic [7:0] d, input logic h, input logic rl);
        start = 1'b1; tx = d; hold = h; rel = rl;
        step();
        start = 1'b0; rel = 1'b0;
    endtask

    // Step from cycle c0 until done; cs_hi counts cycles with CS high before it.
    task automatic wait_done(input int c0, output int cyc, output int cs_hi);
        cyc = -1; cs_hi = 0;
        for (int c = c0 + 1; c <= c0 + 80; c++) begin
            step();
            if (done) begin
                cyc = c;
                break;
            end
            if (cs_n) cs_hi++;
        end
    endtask

    initial begin
        int cyc, cshi, n0, ndone, r1, r2;
        logic prev;

        // ---- reset state
        step(); step();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx", rx, 8'h00);
        chk("rst_cs_n1", cs_n1, 1);
        rst = 1'b0;
        step();

        // ---- single byte, CS released before and after
        sbyte = 8'h3C; sbase = nfall; n0 = nsck;
        accept(8'hA5, 1'b0, 1'b0);
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_cs_n", cs_n, 0);
        chk("t1_c1_mosi", mosi, 1);
        chk("t1_c1_sck", sck, 0);
        wait_done(1, cyc, cshi);
        chk("t1_done_cyc", cyc, 37);
        chk("t1_rx", rx, 8'h3C);
        chk("t1_mosi_bits", mcap, 8'hA5);
        chk("t1_nsck", nsck - n0, 8);
        chk("t1_cs_n_done", cs_n, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_cs_low_run", cshi, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_cs_n_after", cs_n, 1);

        // ---- held CS, back-to-back start in the DONE cycle
        sbyte = 8'h96; sbase = nfall; n0 = nsck;
        accept(8'h9F, 1'b1, 1'b0);
        wait_done(1, cyc, cshi);
        chk("t2a_done_cyc", cyc, 35);
        chk("t2a_rx", rx, 8'h96);
        chk("t2a_mosi_bits", mcap, 8'h9F);
        chk("t2a_cs_n_done", cs_n, 0);
        chk("t2a_cs_low_run", cshi, 0);
        sbyte = 8'hC3; sbase = nfall; n0 = nsck;
        accept(8'h00, 1'b0, 1'b0);
        chk("t2b_c1_cs_n", cs_n, 0);
        chk("t2b_c1_busy", busy, 1);
        wait_done(1, cyc, cshi);
        chk("t2b_done_cyc", cyc, 35);
        chk("t2b_rx", rx, 8'hC3);
        chk("t2b_mosi_bits", mcap, 8'h00);
        chk("t2b_nsck", nsck - n0, 8);
        chk("t2b_cs_low_run", cshi, 0);
        chk("t2b_cs_n_done", cs_n, 1);
        step();

        // ---- start while busy is ignored
        sbyte = 8'hE7; sbase = nfall; n0 = nsck;
        accept(8'h55, 1'b0, 1'b0);
        ndone = 0; cyc = -1;
        for (int c = 2; c <= 70; c++) begin
            step();
            if (c == 5)  begin start = 1'b1; tx = 8'hFF; hold = 1'b1; end
            if (c == 6)  start = 1'b0;
            if (c == 20) begin start = 1'b1; tx = 8'h00; hold = 1'b1; end
            if (c == 21) start = 1'b0;
            if (done) begin
                ndone++;
                if (cyc < 0) cyc = c;
            end
        end
        hold = 1'b0;
        chk("t3_ndone", ndone, 1);
        chk("t3_done_cyc", cyc, 37);
        chk("t3_mosi_bits", mcap, 8'h55);
        chk("t3_nsck", nsck - n0, 8);
        chk("t3_rx", rx, 8'hE7);
        chk("t3_cs_n_end", cs_n, 1);

        // ---- reset mid-transfer
        sbyte = 8'h3C; sbase = nfall;
        accept(8'hA5, 1'b0, 1'b0);
        for (int c = 2; c <= 12; c++) step();
        rst = 1'b1;
        step();
        chk("t4_cs_n", cs_n, 1);
        chk("t4_sck", sck, 0);
        chk("t4_mosi", mosi, 0);
        chk("t4_busy", busy, 0);
        chk("t4_rx", rx, 8'h00);
        rst = 1'b0;
        step();
        sbyte = 8'h24; sbase = nfall; n0 = nsck;
        accept(8'h81, 1'b0, 1'b0);
        chk("t4b_c1_cs_n", cs_n, 0);
        wait_done(1, cyc, cshi);
        chk("t4b_done_cyc", cyc, 37);
        chk("t4b_rx", rx, 8'h24);
        chk("t4b_mosi_bits", mcap, 8'h81);
        step();

        // ---- held CS: start beats cs_release, then release and re-release
        sbyte = 8'h00; sbase = nfall;
        accept(8'h12, 1'b1, 1'b0);
        wait_done(1, cyc, cshi);
        chk("t5a_done_cyc", cyc, 35);
        step(); step();
        chk("t5_idle_cs_n", cs_n, 0);
        chk("t5_idle_busy", busy, 0);
        sbase = nfall;
        accept(8'h34, 1'b1, 1'b1);
        chk("t5b_c1_busy", busy, 1);
        wait_done(1, cyc, cshi);
        chk("t5b_done_cyc", cyc, 33);
        chk("t5b_cs_low_run", cshi, 0);
        chk("t5b_cs_n_done", cs_n, 0);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        chk("t5c_c1_busy", busy, 1);
        chk("t5c_c1_cs_n", cs_n, 0);
        step();
        chk("t5c_c2_busy", busy, 1);
        chk("t5c_c2_done", done, 0);
        step();
        chk("t5c_c3_busy", busy, 0);
        chk("t5c_c3_cs_n", cs_n, 1);
        chk("t5c_c3_done", done, 0);
        rel = 1'b1;
        step();
        rel = 1'b0;
        chk("t5d_busy", busy, 0);
        step();
        chk("t5d_busy2", busy, 0);
        chk("t5d_cs_n", cs_n, 1);

        // ---- CLK_DIV=1, all ones out, MISO low
        n0 = nsck1;
        start1 = 1'b1; tx1 = 8'hFF; hold1 = 1'b0;
        step();
        start1 = 1'b0;
        prev = sck1; cyc = -1; r1 = -1; r2 = -1;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (sck1 && !prev) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
            prev = sck1;
            if (done1) begin
                cyc = c;
                break;
            end
        end
        chk("t6_done_cyc", cyc, 19);
        chk("t6_rx", rx1, 8'h00);
        chk("t6_mosi_bits", mcap1, 8'hFF);
        chk("t6_nsck", nsck1 - n0, 8);
        chk("t6_sck_period", r2 - r1, 2);
        chk("t6_cs_n_done", cs_n1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
